// File: rtl/socket_operand_buffer_pkg.sv
// Shared stream types and sizing helpers for the socket-to-adder operand path.
`timescale 1ns/1ps
package sim_stream_pkg;

  localparam int DEFAULT_OP_WIDTH = 32;

  typedef struct packed {
    logic [DEFAULT_OP_WIDTH-1:0] din1;
    logic [DEFAULT_OP_WIDTH-1:0] din0;
  } operand_pair_t;

  // Occupancy must represent 0..depth inclusive, hence one bit beyond the pointer width.
  function automatic int levelWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/socket_operand_buffer_sync_fwft_fifo.sv
// Generic first-word-fall-through FIFO; the head entry is presented straight from storage registers.
`timescale 1ns/1ps
module sync_fwft_fifo
  import sim_stream_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             i_wrData,
  input  logic                         i_wrValid,
  output logic                         o_wrReady,
  output logic [WIDTH-1:0]             o_rdData,
  output logic                         o_rdValid,
  input  logic                         i_rdReady,
  output logic [levelWidth(DEPTH)-1:0] o_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = levelWidth(DEPTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  // Full/empty come from the registered level only, so ready never depends on a same-cycle pop.
  assign o_wrReady = (r_level < FULL_LEVEL);
  assign o_rdValid = (r_level != '0);
  assign o_rdData  = r_mem[r_rdPtr];
  assign o_level   = r_level;
  assign w_push    = i_wrValid & o_wrReady;
  assign w_pop     = o_rdValid & i_rdReady;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= i_wrData;
        r_wrPtr        <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/socket_operand_buffer.sv
// Elastic operand buffer between the socket receive stream and the adder, with an accepted-word counter.
`timescale 1ns/1ps
module socket_operand_buffer
  import sim_stream_pkg::*;
#(
  parameter int OP_WIDTH  = DEFAULT_OP_WIDTH,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2*OP_WIDTH-1:0]        s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [OP_WIDTH-1:0]          din0,
  output logic [OP_WIDTH-1:0]          din1,
  output logic                         din_valid,
  input  logic                         din_ready,
  output logic [levelWidth(DEPTH)-1:0] level,
  output logic [CNT_WIDTH-1:0]         word_cnt
);

  logic [2*OP_WIDTH-1:0] w_headPair;
  logic                  w_accept;
  logic [CNT_WIDTH-1:0]  r_wordCnt;

  sync_fwft_fifo #(
    .WIDTH (2*OP_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wrData  (s_data),
    .i_wrValid (s_valid),
    .o_wrReady (s_ready),
    .o_rdData  (w_headPair),
    .o_rdValid (din_valid),
    .i_rdReady (din_ready),
    .o_level   (level)
  );

  assign din0     = w_headPair[OP_WIDTH-1:0];
  assign din1     = w_headPair[2*OP_WIDTH-1:OP_WIDTH];
  assign w_accept = s_valid & s_ready;
  assign word_cnt = r_wordCnt;

  // Free-running modulo counter of accepted words; wraps rather than saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wordCnt <= '0;
    end else if (w_accept) begin
      r_wordCnt <= r_wordCnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_socket_operand_buffer.sv
// Scoreboard bench for socket_operand_buffer: directed scenarios plus a randomised handshake soak.
`timescale 1ns/1ps
module tb_socket_operand_buffer;
  import sim_stream_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] din0;
  logic [31:0] din1;
  logic        din_valid;
  logic        din_ready = 1'b0;
  logic [2:0]  level;
  logic [3:0]  word_cnt;

  operand_pair_t expQ[$];
  int assertCount = 0;
  int failCount   = 0;
  int popCount    = 0;

  socket_operand_buffer #(
    .OP_WIDTH  (32),
    .DEPTH     (4),
    .CNT_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .din0      (din0),
    .din1      (din1),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .level     (level),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: a transfer-out completes on the next rising edge whenever valid and ready are seen here.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("level_bound", 64'(level <= 3'd4), 64'd1);
      if (din_valid && din_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_pair", {din1, din0}, 64'd0 - 64'd1);
        end else begin
          checkOutput("pair_order", {din1, din0}, expQ.pop_front());
          popCount++;
        end
      end
    end
  end

  // Pushes one word, holding it until accepted; records the expected pair at the accepting edge.
  task automatic applyStimulus(input logic [63:0] data, input int maxWait);
    bit taken = 0;
    int n = 0;
    s_data  = data;
    s_valid = 1'b1;
    while (!taken && n < maxWait) begin
      @(negedge clk);
      if (s_ready) begin
        expQ.push_back(data);
        taken = 1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    if (!taken) checkOutput("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic resetDut();
    rst     = 1'b1;
    s_valid = 1'b0;
    expQ.delete();
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while ((expQ.size() != 0 || level != 3'd0) && n < maxCycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_queue_empty", 64'(expQ.size()), 64'd0);
    checkOutput("drain_level_zero", 64'(level), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int popBase;
    int n;
    time tStart;

    // Reset state
    resetDut();
    checkOutput("reset_s_ready", 64'(s_ready), 64'd1);
    checkOutput("reset_din_valid", 64'(din_valid), 64'd0);
    checkOutput("reset_din", {din1, din0}, 64'd0);
    checkOutput("reset_level", 64'(level), 64'd0);
    checkOutput("reset_word_cnt", 64'(word_cnt), 64'd0);

    // Scenario 1: three words, each presented one cycle after acceptance
    din_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus({32'(2*i+2), 32'(2*i+1)}, 10);
      checkOutput("t1_latency_valid", 64'(din_valid), 64'd1);
      checkOutput("t1_din0", 64'(din0), 64'(2*i+1));
      checkOutput("t1_din1", 64'(din1), 64'(2*i+2));
      checkOutput("t1_adder_sum", 64'(din0 + din1), 64'(4*i+3));
    end
    waitDrain(20);
    checkOutput("t1_word_cnt", 64'(word_cnt), 64'd3);

    // Scenario 2: back-pressure fills the buffer; ready returns only after the pop
    din_ready = 1'b0;
    popBase   = popCount;
    fork
      begin
        for (int i = 0; i < 5; i++) applyStimulus({32'(16'h200 + i), 32'(16'h100 + i)}, 30);
      end
      begin
        n = 0;
        while (level != 3'd4 && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        checkOutput("t2_full_level", 64'(level), 64'd4);
        checkOutput("t2_full_s_ready", 64'(s_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t2_fifth_refused", 64'(level), 64'd4);
        din_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t2_ready_after_pop", 64'(s_ready), 64'd1);
        checkOutput("t2_level_after_pop", 64'(level), 64'd3);
      end
    join
    waitDrain(30);
    checkOutput("t2_pop_count", 64'(popCount - popBase), 64'd5);
    checkOutput("t2_word_cnt", 64'(word_cnt), 64'd8);

    // Scenario 3: sustained traffic starting from full
    din_ready = 1'b0;
    popBase   = popCount;
    for (int i = 0; i < 4; i++) applyStimulus({32'hC0DE_0000, 32'(i)}, 10);
    din_ready = 1'b1;
    tStart    = $time;
    for (int i = 0; i < 20; i++) applyStimulus({32'hBEEF_0000, 32'(100 + i)}, 10);
    checkOutput("t3_throughput", 64'((($time - tStart) / 10) <= 40), 64'd1);
    waitDrain(30);
    checkOutput("t3_pop_count", 64'(popCount - popBase), 64'd24);
    checkOutput("t3_word_cnt_wrap", 64'(word_cnt), 64'd0);

    // Scenario 4: asynchronous reset mid-burst
    din_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus({32'hDEAD_0000, 32'(i)}, 10);
    checkOutput("t4_level_before", 64'(level), 64'd3);
    rst = 1'b1;
    #2;
    expQ.delete();
    checkOutput("t4_async_din_valid", 64'(din_valid), 64'd0);
    checkOutput("t4_async_level", 64'(level), 64'd0);
    checkOutput("t4_async_word_cnt", 64'(word_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    din_ready = 1'b1;
    applyStimulus({32'hA, 32'hB}, 10);
    checkOutput("t4_first_din0", 64'(din0), 64'hB);
    checkOutput("t4_first_din1", 64'(din1), 64'hA);
    waitDrain(10);
    checkOutput("t4_word_cnt", 64'(word_cnt), 64'd1);

    // Scenario 5: counter wrap with a 4-bit counter
    resetDut();
    din_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      applyStimulus({32'(i + 1000), 32'(i)}, 10);
      if (i == 15) checkOutput("t5_cnt_all_ones", 64'(word_cnt), 64'd15);
      if (i == 16) checkOutput("t5_cnt_wrapped", 64'(word_cnt), 64'd0);
    end
    checkOutput("t5_cnt_after_17", 64'(word_cnt), 64'd1);
    waitDrain(10);

    // Scenario 6: random valid/ready soak against the scoreboard
    s_valid   = 1'b0;
    din_ready = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      bit taken;
      @(negedge clk);
      taken = s_valid && s_ready;
      if (taken) expQ.push_back(s_data);
      @(posedge clk);
      #1;
      if (taken || !s_valid) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = {$urandom, $urandom};
      end
      din_ready = 1'($urandom_range(0, 1));
    end
    s_valid   = 1'b0;
    din_ready = 1'b1;
    waitDrain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
